// File: rtl/mix_tree_sequencer.sv
// Sequences a bank of binary mixing trees: fill the leaves, mix level by level from the
// deepest level up to the root, drain the outlets, then report done. Optional feature macro:
// MIX_TREE_PAUSE_EN adds a pause input that freezes the running phase.
module mix_tree_sequencer #(
   parameter int  TREES        = 4,
   parameter int  DEPTH        = 2,
   parameter int  FILL_CYCLES  = 4,
   parameter int  MIX_CYCLES   = 8,
   parameter int  DRAIN_CYCLES = 4,
   localparam int L            = 2**DEPTH,
   localparam int M            = L - 1,
   localparam int LW           = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [TREES-1:0]   tree_mask,
   input  logic               abort,
`ifdef MIX_TREE_PAUSE_EN
   input  logic               pause,
`endif
   output logic               busy,
   output logic               done,
   output logic [TREES*L-1:0] inlet_valve,
   output logic [TREES*M-1:0] mix_en,
   output logic [TREES-1:0]   outlet_valve,
   output logic [LW-1:0]      level
);

   localparam int MAX_FM  = (FILL_CYCLES > MIX_CYCLES) ? FILL_CYCLES : MIX_CYCLES;
   localparam int MAX_ALL = (MAX_FM > DRAIN_CYCLES) ? MAX_FM : DRAIN_CYCLES;
   localparam int CW      = $clog2(MAX_ALL + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_MIX,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [LW-1:0]      lvl_q, lvl_d;
   logic [TREES-1:0]   mask_q, mask_d;

   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [TREES*L-1:0] inlet_q, inlet_d;
   logic [TREES*M-1:0] mix_q, mix_d;
   logic [TREES-1:0]   outlet_q, outlet_d;
   logic [LW-1:0]      level_q, level_d;

   logic               active;
   logic               paused;
   logic               cnt_last;

   assign active   = (state_q == S_FILL) || (state_q == S_MIX) || (state_q == S_DRAIN);
   assign cnt_last = (cnt_q == CW'(1));

`ifdef MIX_TREE_PAUSE_EN
   // Abort takes precedence, so a paused phase can still be cancelled.
   assign paused = pause & active & ~abort;
`else
   assign paused = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lvl_d   = lvl_q;
      mask_d  = mask_q;
      unique case (state_q)
         S_IDLE: begin
            if (start && (tree_mask != '0)) begin
               state_d = S_FILL;
               cnt_d   = CW'(FILL_CYCLES);
               mask_d  = tree_mask;
            end
         end
         S_FILL: begin
            if (cnt_last) begin
               state_d = S_MIX;
               lvl_d   = LW'(DEPTH - 1);
               cnt_d   = CW'(MIX_CYCLES);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_MIX: begin
            if (!cnt_last) begin
               cnt_d = cnt_q - CW'(1);
            end else if (lvl_q == '0) begin
               state_d = S_DRAIN;
               cnt_d   = CW'(DRAIN_CYCLES);
            end else begin
               lvl_d = lvl_q - LW'(1);
               cnt_d = CW'(MIX_CYCLES);
            end
         end
         S_DRAIN: begin
            if (cnt_last) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (paused) begin
         state_d = state_q;
         cnt_d   = cnt_q;
         lvl_d   = lvl_q;
      end

      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         lvl_d   = '0;
         mask_d  = '0;
      end
   end

   // Output registers are decoded from the current state, so every output lags the
   // state by one edge and no input reaches a port combinationally.
   always_comb begin
      busy_d  = (state_q != S_IDLE);
      done_d  = (state_q == S_DONE);
      level_d = (state_q == S_MIX) ? lvl_q : '0;
   end

   for (genvar gi = 0; gi < TREES; gi++) begin : g_tree
      logic tree_on;
      assign tree_on             = mask_q[gi] & ~paused;
      assign inlet_d[gi*L +: L]  = {L{tree_on & (state_q == S_FILL)}};
      assign outlet_d[gi]        = tree_on & (state_q == S_DRAIN);
      for (genvar gj = 0; gj < M; gj++) begin : g_node
         // Heap node gj sits on level floor(log2(gj+1)).
         localparam int NODE_LVL = $clog2(gj + 2) - 1;
         assign mix_d[gi*M + gj] = tree_on & (state_q == S_MIX) & (lvl_q == LW'(NODE_LVL));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         lvl_q    <= '0;
         mask_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         inlet_q  <= '0;
         mix_q    <= '0;
         outlet_q <= '0;
         level_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         lvl_q    <= lvl_d;
         mask_q   <= mask_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         inlet_q  <= inlet_d;
         mix_q    <= mix_d;
         outlet_q <= outlet_d;
         level_q  <= level_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign inlet_valve  = inlet_q;
   assign mix_en       = mix_q;
   assign outlet_valve = outlet_q;
   assign level        = level_q;

endmodule

// File: tb/tb_mix_tree_sequencer.sv
// Bench for mix_tree_sequencer: two instances (4 trees depth 2, 2 trees depth 3) checked every
// cycle against a schedule-based model, plus fixed expectations from the worked timing examples.
module tb_mix_tree_sequencer;

   localparam int F  = 4;
   localparam int MX = 8;
   localparam int D  = 4;

   typedef struct packed {
      logic        busy;
      logic        done;
      logic [63:0] inlet;
      logic [63:0] mix;
      logic [7:0]  outlet;
      logic [3:0]  level;
   } item_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        pause = 1'b0;
   logic [3:0]  tree_mask = 4'h0;

   logic        busy0, done0, busy1, done1;
   logic [15:0] inl0, inl1;
   logic [11:0] mix0;
   logic [13:0] mix1;
   logic [3:0]  out0;
   logic [1:0]  out1;
   logic [1:0]  lvl0, lvl1;

   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   bit    act [2];
   int    idx [2];
   logic [7:0] mk [2];
   item_t exp_q [2];
   int    acc_cyc [2];
   int    done_cnt [2];
   int    a, n0;

   always #5 clk = ~clk;

   mix_tree_sequencer dut0 (
      .clk(clk), .rst(rst), .start(start), .tree_mask(tree_mask), .abort(abort),
`ifdef MIX_TREE_PAUSE_EN
      .pause(pause),
`endif
      .busy(busy0), .done(done0), .inlet_valve(inl0), .mix_en(mix0),
      .outlet_valve(out0), .level(lvl0)
   );

   mix_tree_sequencer #(.TREES(2), .DEPTH(3)) dut1 (
      .clk(clk), .rst(rst), .start(start), .tree_mask(tree_mask[1:0]), .abort(abort),
`ifdef MIX_TREE_PAUSE_EN
      .pause(pause),
`endif
      .busy(busy1), .done(done1), .inlet_valve(inl1), .mix_en(mix1),
      .outlet_valve(out1), .level(lvl1)
   );

   function automatic int trees_of(int i);
      return (i == 0) ? 4 : 2;
   endfunction

   function automatic int depth_of(int i);
      return (i == 0) ? 2 : 3;
   endfunction

   function automatic int run_len(int depth);
      return F + depth * MX + D + 1;
   endfunction

   // Expected outputs idx cycles after a run is accepted, straight from the phase schedule.
   function automatic item_t sched(int trees, int depth, logic [7:0] m, int k);
      item_t r;
      int    nl, nm, lv;
      r      = '0;
      r.busy = 1'b1;
      nl     = 1 << depth;
      nm     = nl - 1;
      if (k < F) begin
         for (int t = 0; t < trees; t++)
            if (m[t]) for (int j = 0; j < nl; j++) r.inlet[t*nl + j] = 1'b1;
      end else if (k < F + depth * MX) begin
         lv      = depth - 1 - (k - F) / MX;
         r.level = 4'(lv);
         for (int t = 0; t < trees; t++)
            if (m[t]) for (int n = (1 << lv) - 1; n <= (1 << (lv + 1)) - 2; n++)
               r.mix[t*nm + n] = 1'b1;
      end else if (k < F + depth * MX + D) begin
         for (int t = 0; t < trees; t++) r.outlet[t] = m[t];
      end else begin
         r.done = 1'b1;
      end
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            act[i]   = 1'b0;
            exp_q[i] = '0;
         end
      end else begin
         cyc = cyc + 1;
         for (int i = 0; i < 2; i++) begin
            logic [7:0] m;
            item_t it;
            m = (i == 0) ? {4'h0, tree_mask} : {6'h0, tree_mask[1:0]};
            if (act[i]) begin
               it = sched(trees_of(i), depth_of(i), mk[i], idx[i]);
               if (abort) begin
                  exp_q[i] = it;
                  act[i]   = 1'b0;
               end else if (pause && idx[i] < run_len(depth_of(i)) - 1) begin
                  it.inlet  = '0;
                  it.mix    = '0;
                  it.outlet = '0;
                  exp_q[i]  = it;
               end else begin
                  exp_q[i] = it;
                  idx[i]   = idx[i] + 1;
                  if (idx[i] == run_len(depth_of(i))) act[i] = 1'b0;
               end
            end else begin
               exp_q[i] = '0;
               if (start && m != 8'h0) begin
                  act[i]     = 1'b1;
                  idx[i]     = 0;
                  mk[i]      = m;
                  acc_cyc[i] = cyc;
                  if (i == 0) $display("run accepted at edge %0d mask %b", cyc, tree_mask);
               end
            end
         end
      end
   end

   always @(posedge clk) begin
      item_t g0, g1;
      #2;
      g0 = '0;
      g0.busy = busy0; g0.done = done0; g0.inlet[15:0] = inl0; g0.mix[11:0] = mix0;
      g0.outlet[3:0] = out0; g0.level[1:0] = lvl0;
      g1 = '0;
      g1.busy = busy1; g1.done = done1; g1.inlet[15:0] = inl1; g1.mix[13:0] = mix1;
      g1.outlet[1:0] = out1; g1.level[1:0] = lvl1;
      checks = checks + 2;
      if (g0 !== exp_q[0]) begin
         errors = errors + 1;
         $display("FAIL model_d2 edge %0d got b%b d%b in%h mx%h o%h l%0d want b%b d%b in%h mx%h o%h l%0d",
                  cyc, g0.busy, g0.done, g0.inlet, g0.mix, g0.outlet, g0.level,
                  exp_q[0].busy, exp_q[0].done, exp_q[0].inlet, exp_q[0].mix, exp_q[0].outlet, exp_q[0].level);
      end
      if (g1 !== exp_q[1]) begin
         errors = errors + 1;
         $display("FAIL model_d3 edge %0d got b%b d%b in%h mx%h o%h l%0d want b%b d%b in%h mx%h o%h l%0d",
                  cyc, g1.busy, g1.done, g1.inlet, g1.mix, g1.outlet, g1.level,
                  exp_q[1].busy, exp_q[1].done, exp_q[1].inlet, exp_q[1].mix, exp_q[1].outlet, exp_q[1].level);
      end
      if (done0) done_cnt[0] = done_cnt[0] + 1;
      if (done1) done_cnt[1] = done_cnt[1] + 1;
   end

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
      checks = checks + 1;
      if (got !== want) begin
         errors = errors + 1;
         $display("FAIL %s got %h want %h", nm, got, want);
      end
   endtask

   // Returns 3 time units after the edge with the given number, bounded.
   task automatic at_edge(input int e);
      int guard;
      guard = 0;
      do begin
         @(posedge clk);
         #3;
         guard++;
      end while (cyc < e && guard < 2000);
      if (cyc < e) check("edge_wait_timeout", 64'(cyc), 64'(e));
   endtask

   task automatic start_run(input logic [3:0] m);
      @(negedge clk);
      start     = 1'b1;
      tree_mask = m;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic pulse_start_at(input int e);
      at_edge(e - 1);
      @(negedge clk);
      start     = 1'b1;
      tree_mask = 4'hF;
      @(negedge clk);
      start     = 1'b0;
      tree_mask = 4'b0101;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired at edge %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      check("reset_busy", 64'(busy0), 64'h0);
      check("reset_outputs", {inl0, mix0, out0, lvl0, done0}, 64'h0);
      rst = 1'b0;

      // Full run, all trees.
      start_run(4'hF);
      a = acc_cyc[0];
      at_edge(a + 1);
      check("fill_inlet_d2", 64'(inl0), 64'hFFFF);
      check("fill_inlet_d3", 64'(inl1), 64'hFFFF);
      at_edge(a + 5);
      check("mix_lvl1_d2", 64'(mix0), 64'hDB6);
      check("mix_lvl2_d3", 64'(mix1), 64'h3C78);
      check("level_d2", 64'(lvl0), 64'h1);
      at_edge(a + 13);
      check("mix_lvl0_d2", 64'(mix0), 64'h249);
      at_edge(a + 21);
      check("drain_outlet_d2", 64'(out0), 64'hF);
      check("mix_lvl0_d3", 64'(mix1), 64'h81);
      at_edge(a + 25);
      check("done_edge25", 64'(done0), 64'h1);
      at_edge(a + 26);
      check("busy_low_edge26", 64'(busy0), 64'h0);
      at_edge(a + 33);
      check("done_d3_edge33", 64'(done1), 64'h1);
      at_edge(a + 36);

      // Partial mask with start repeated during the run.
      n0 = done_cnt[0];
      start_run(4'b0101);
      a = acc_cyc[0];
      at_edge(a + 1);
      check("mask0101_inlet_d2", 64'(inl0), 64'h0F0F);
      check("mask01_inlet_d3", 64'(inl1), 64'h00FF);
      pulse_start_at(a + 5);
      pulse_start_at(a + 25);
      check("mask0101_done25", 64'(done0), 64'h1);
      at_edge(a + 40);
      check("single_done", 64'(done_cnt[0] - n0), 64'h1);

      // Start with an empty mask is ignored.
      start_run(4'h0);
      at_edge(cyc + 3);
      check("mask0_busy", 64'({busy0, busy1}), 64'h0);

      // Abort in MIX level 1, then a fresh run.
      start_run(4'hF);
      a  = acc_cyc[0];
      n0 = done_cnt[0];
      at_edge(a + 11);
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      at_edge(a + 13);
      check("abort_clear", {inl0, mix0, out0, lvl0, busy0, done0}, 64'h0);
      start_run(4'hF);
      check("restart_edge", 64'(acc_cyc[0]), 64'(a + 14));
      at_edge(a + 14 + 25);
      check("restart_done", 64'(done0), 64'h1);
      check("abort_no_done", 64'(done_cnt[0] - n0), 64'h1);
      at_edge(cyc + 12);

      // Asynchronous reset mid-run.
      start_run(4'hF);
      a = acc_cyc[0];
      at_edge(a + 19);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_async_d2", {inl0, mix0, out0, lvl0, busy0, done0}, 64'h0);
      check("rst_async_d3", {inl1, mix1, out1, lvl1, busy1, done1}, 64'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      at_edge(cyc + 2);
      check("rst_idle", 64'({busy0, busy1}), 64'h0);

`ifdef MIX_TREE_PAUSE_EN
      // Three paused cycles in FILL push done from edge 25 to edge 28.
      start_run(4'hF);
      a = acc_cyc[0];
      at_edge(a + 1);
      @(negedge clk); pause = 1'b1;
      repeat (3) @(negedge clk);
      pause = 1'b0;
      check("pause_inlet_zero", 64'(inl0), 64'h0);
      at_edge(a + 28);
      check("pause_done28", 64'(done0), 64'h1);
      at_edge(cyc + 12);
`endif

      // Randomized traffic checked by the per-cycle model.
      repeat (500) begin
         @(negedge clk);
         start     = ($urandom_range(0, 7) == 0);
         tree_mask = 4'($urandom);
         abort     = ($urandom_range(0, 39) == 0);
`ifdef MIX_TREE_PAUSE_EN
         pause     = ($urandom_range(0, 9) == 0);
`endif
      end
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      pause = 1'b0;
      repeat (40) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mix_tree_sequencer.md
# mix_tree_sequencer

Timed controller for a bank of `TREES` identical binary mixing trees of depth `DEPTH`. This is the successor to the fixed 4-tree, depth-2 mixer netlist.

On a start request it drives the leaf inlet valves and then enables the mixers level by level, deepest level first. It then opens the per-tree outlet valves and signals completion. It sits between the assay scheduler, which uses a start/done handshake, and the valve/mixer actuation drivers of the tree array.

## Interface
Parameters:
- `TREES`, 4: number of independent trees (≥1).
- `DEPTH`, 2: tree depth (≥1). Leaves per tree `L=2**DEPTH`; mixers per tree `M=L-1`.
- `FILL_CYCLES`, 4: inlet-open duration (≥1).
- `MIX_CYCLES`, 8: mix duration per level (≥1).
- `DRAIN_CYCLES`, 4: outlet-open duration (≥1).

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: run request; sampled only in IDLE.
- `tree_mask`, in, `TREES`: trees taking part in the run; latched on start acceptance.
- `abort`, in, 1: synchronous cancel of the current run.
- `busy`, out, 1: high in every state other than IDLE.
- `done`, out, 1: one-cycle pulse on completion.
- `inlet_valve`, out, `TREES*L`: bit `t*L+j` drives leaf inlet `j` of tree `t`.
- `mix_en`, out, `TREES*M`: bit `t*M+n` drives mixer `n` of tree `t`, in heap order. Node 0 is the root; the children of `n` are `2n+1` and `2n+2`; level `k` holds nodes `2**k-1 .. 2**(k+1)-2`.
- `outlet_valve`, out, `TREES`: root outlet of each tree.
- `level`, out, `$clog2(DEPTH+1)`: current mix level; 0 outside MIX.

## Operation
- FSM states: IDLE, FILL, MIX, DRAIN, DONE.
- IDLE:
  - `start`=1 and `tree_mask`≠0: latch the mask into `mask_q` and go to FILL.
  - `start` with `tree_mask`=0 is ignored; the FSM stays in IDLE and no `done` is produced.
- FILL: every inlet bit of each tree with `mask_q[t]`=1 is high for `FILL_CYCLES` cycles. Then go to MIX with `level`=`DEPTH-1`.
- MIX:
  - For masked trees, only the mixers of the current `level` are enabled, for `MIX_CYCLES` cycles.
  - At the end of a level, `level` decrements. After level 0 completes, go to DRAIN.
- DRAIN: `outlet_valve[t]`=`mask_q[t]` for `DRAIN_CYCLES` cycles. Then go to DONE.
- DONE: `done`=1 for exactly one cycle, then return to IDLE.
- Unmasked trees never see any asserted output bit.
- `start` while `busy` is ignored, and `tree_mask` changes while `busy` have no effect.
- A single down-counter of width `$clog2(max(FILL,MIX,DRAIN)+1)` is loaded on each state or level entry. The phase ends when the counter reaches 1; there is no wrap.
- `abort`=1 in FILL, MIX, DRAIN or DONE:
  - Next cycle: IDLE, all actuation outputs 0, `level`=0.
  - `done` is not pulsed. If `abort` lands in the DONE cycle, that pulse still appears in the same cycle.
- `abort` in IDLE has no effect. `abort` and `start` together in IDLE: `start` wins.

## Timing
- Reset values: state IDLE; `busy`, `done`, `inlet_valve`, `mix_en`, `outlet_valve`, `level`, `mask_q` and the counter all 0.
- All outputs are registered. Nothing is combinational from the inputs.
- With `start` accepted at edge 0:
  - FILL outputs are high after edges 1..`FILL_CYCLES`.
  - Mix level `k` is enabled for the next `MIX_CYCLES` cycles, from `DEPTH-1` down to 0.
  - DRAIN follows the last mix level.
  - `done` is high after edge `1+FILL+DEPTH*MIX+DRAIN`.
- With default parameters, `done` is high after edge 25 and `busy` is low after edge 26. The earliest next accepted `start` is sampled at edge 26.
- Phase transitions are gap-free: each phase's outputs drop on the same edge that raises the next phase's outputs.
- Reset asserted mid-run: all outputs go to 0 immediately (asynchronous), with no `done`.

## Configuration
- `MIX_TREE_PAUSE_EN` defined:
  - Adds input `pause` (1 bit).
  - `pause`=1 in FILL, MIX or DRAIN freezes the counter, `level` and the state, and forces all actuation outputs to 0.
  - On release, the phase resumes with the remaining count; the total completion time grows by exactly the number of paused cycles.
  - `pause` has no effect in IDLE or DONE, and `abort` overrides `pause`.
- `MIX_TREE_PAUSE_EN` undefined: no `pause` port, and timing is exactly as above.

## Test plan
- Defaults, `tree_mask`=4'b1111, 1-cycle start:
  - `inlet_valve`=16'hFFFF for 4 cycles.
  - `mix_en` per tree 3'b110 for 8 cycles, then 3'b001 for 8 cycles.
  - `outlet_valve`=4'hF for 4 cycles.
  - `done` pulses after edge 25.
- `tree_mask`=4'b0101: only bits of trees 0 and 2 ever assert; the timing matches the first test.
- `start` repeated at edges 5 and 25 during a run: the run is unchanged and exactly one `done` is produced. `start` with mask 0: `busy` stays 0.
- `abort` at edge 12 (in MIX, level 1): all outputs are 0 after edge 13 and `done` never pulses. A new `start` at edge 14 runs a full sequence.
- `rst` pulsed at edge 20: outputs clear at once and the FSM is in IDLE. Also run with `DEPTH`=3, `TREES`=2, mask 2'b11: `mix_en` steps through levels 2, 1, 0 (nodes 3–6, 1–2, then 0), and `done` comes after edge 1+4+24+4=33.
- With `MIX_TREE_PAUSE_EN`, `pause` held for 3 cycles inside FILL: outputs are 0 during the pause and `done` moves from edge 25 to edge 28.
